// File: rtl/sat_accum_lanes_pkg.sv
// Common definitions for the saturating lane accumulator: numeric
// interpretation, FSM state encoding and the clamp limits helper.
package sat_accum_lanes_pkg;

  // Interpretation of lane data.
  typedef enum logic {
    UNSIGNED = 1'b0,
    SIGNED   = 1'b1
  } num_t;

  // Frame FSM: IDLE means the accumulators hold no partial frame.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // Clamp limits, returned 64 bits wide; callers keep the low aw bits.
  typedef struct packed {
    logic [63:0] max_v;
    logic [63:0] min_v;
  } sat_lim_t;

  function automatic sat_lim_t sat_limits(input num_t t, input int aw);
    sat_lim_t lim;
    if (t == SIGNED) begin
      lim.max_v = (64'd1 << (aw - 1)) - 64'd1;
      lim.min_v = ~lim.max_v;
    end else begin
      lim.max_v = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
      lim.min_v = '0;
    end
    return lim;
  endfunction

endpackage

// File: rtl/sat_accum_lanes_add_lane.sv
// One lane of the accumulator: extended add, overflow/underflow decode and,
// when SAT_ACCUM_LANES_SATURATE_EN is defined, clamping to the lane limits.
// Purely combinational.
module sat_add_lane
  import sat_accum_lanes_pkg::*;
#(
  parameter int   DWd  = 8,
  parameter int   AWd  = 16,
  parameter num_t Type = UNSIGNED
) (
  input  logic [AWd-1:0] acc,
  input  logic [DWd-1:0] din,
  output logic [AWd-1:0] sum,
  output logic           ovf,
  output logic           udf
);

  localparam logic Sgn = (Type == SIGNED);

`ifdef SAT_ACCUM_LANES_SATURATE_EN
  localparam sat_lim_t       Lim  = sat_limits(Type, AWd);
  localparam logic [AWd-1:0] MaxV = Lim.max_v[AWd-1:0];
  localparam logic [AWd-1:0] MinV = Lim.min_v[AWd-1:0];
`endif

  logic [AWd:0] ext_in;
  logic [AWd:0] ext_acc;
  logic [AWd:0] full;

  // One extra bit on both operands; the top two bits of the result
  // tell whether the true sum left the AWd-bit range.
  assign ext_in  = {{(AWd + 1 - DWd){din[DWd-1] & Sgn}}, din};
  assign ext_acc = {acc[AWd-1] & Sgn, acc};
  assign full    = ext_acc + ext_in;

  // Decode flags and select wrapped or clamped result.
  always_comb begin
    ovf = 1'b0;
    udf = 1'b0;
    if (Sgn) begin
      ovf = (full[AWd:AWd-1] == 2'b01);
      udf = (full[AWd:AWd-1] == 2'b10);
    end else begin
      ovf = full[AWd];
    end
`ifdef SAT_ACCUM_LANES_SATURATE_EN
    if (ovf)      sum = MaxV;
    else if (udf) sum = MinV;
    else          sum = full[AWd-1:0];
`else
    sum = full[AWd-1:0];
`endif
  end

endmodule

// File: rtl/sat_accum_lanes.sv
// Multi-lane streaming frame accumulator with sticky per-lane overflow and
// underflow flags, beat counter and a single registered result beat.
// Define SAT_ACCUM_LANES_SATURATE_EN to clamp lanes instead of wrapping.
module sat_accum_lanes
  import sat_accum_lanes_pkg::*;
#(
  parameter int   DWd   = 8,
  parameter int   AWd   = 16,
  parameter int   NLane = 4,
  parameter int   CntWd = 8,
  parameter num_t Type  = UNSIGNED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NLane*DWd-1:0] i_data,
  input  logic                 i_last,
  input  logic                 i_clear,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NLane*AWd-1:0] o_data,
  output logic [NLane-1:0]     o_ovf,
  output logic [NLane-1:0]     o_udf,
  output logic [CntWd-1:0]     o_cnt
);

  acc_state_e state_reg, state_next;

  logic [NLane-1:0][AWd-1:0] acc_reg;
  logic [NLane-1:0][AWd-1:0] lane_sum;
  logic [NLane-1:0]          lane_ovf;
  logic [NLane-1:0]          lane_udf;
  logic [NLane-1:0]          ovf_reg;
  logic [NLane-1:0]          udf_reg;
  logic [CntWd-1:0]          cnt_reg;
  logic [CntWd-1:0]          cnt_inc;

  logic                      out_valid_reg;
  logic [NLane*AWd-1:0]      out_data_reg;
  logic [NLane-1:0]          out_ovf_reg;
  logic [NLane-1:0]          out_udf_reg;
  logic [CntWd-1:0]          out_cnt_reg;

  logic accept;
  logic frame_end;
  logic restart;

  // Accept whenever the result slot is empty or being drained this cycle.
  assign o_ready   = !(out_valid_reg && !i_ready);
  assign accept    = i_valid && o_ready;
  assign frame_end = accept && i_last && !i_clear;
  assign restart   = i_clear || frame_end;
  assign cnt_inc   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NLane; gi++) begin : g_lane
      logic [AWd-1:0] acc_op;
      // A fresh frame always starts from zero, regardless of stale state.
      assign acc_op = (state_reg == ACCUM) ? acc_reg[gi] : '0;

      sat_add_lane #(
        .DWd (DWd),
        .AWd (AWd),
        .Type(Type)
      ) u_add (
        .acc(acc_op),
        .din(i_data[gi*DWd +: DWd]),
        .sum(lane_sum[gi]),
        .ovf(lane_ovf[gi]),
        .udf(lane_udf[gi])
      );
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state: clear or a closing beat returns to IDLE.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept && !i_clear && !i_last) state_next = ACCUM;
      ACCUM:   if (i_clear || (accept && i_last)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Running sums, sticky flags and beat counter for the open frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      ovf_reg <= '0;
      udf_reg <= '0;
      cnt_reg <= '0;
    end else if (restart) begin
      acc_reg <= '0;
      ovf_reg <= '0;
      udf_reg <= '0;
      cnt_reg <= '0;
    end else if (accept) begin
      acc_reg <= lane_sum;
      ovf_reg <= ovf_reg | lane_ovf;
      udf_reg <= udf_reg | lane_udf;
      cnt_reg <= cnt_inc;
    end
  end

  // Result register: loaded at frame close, held until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= '0;
      out_udf_reg   <= '0;
      out_cnt_reg   <= '0;
    end else if (frame_end) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= lane_sum;
      out_ovf_reg   <= ovf_reg | lane_ovf;
      out_udf_reg   <= udf_reg | lane_udf;
      out_cnt_reg   <= cnt_inc;
    end else if (i_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign o_valid = out_valid_reg;
  assign o_data  = out_data_reg;
  assign o_ovf   = out_ovf_reg;
  assign o_udf   = out_udf_reg;
  assign o_cnt   = out_cnt_reg;

endmodule

// File: tb/tb_sat_accum_lanes.sv
// Bench for sat_accum_lanes: a SIGNED (CntWd=2) and an UNSIGNED (CntWd=3)
// instance, 4 lanes of 8 bits, share all inputs and are checked against a
// frame-level arithmetic model, a vector table and directed sequences.
module tb_sat_accum_lanes;
  import sat_accum_lanes_pkg::*;

`ifdef SAT_ACCUM_LANES_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_last = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_ready = 1'b0;

  logic        s_o_ready, s_o_valid, u_o_ready, u_o_valid;
  logic [31:0] s_o_data, u_o_data;
  logic [3:0]  s_o_ovf, s_o_udf, u_o_ovf, u_o_udf;
  logic [1:0]  s_o_cnt;
  logic [2:0]  u_o_cnt;

  always #5 clk = ~clk;

  sat_accum_lanes #(.DWd(8), .AWd(8), .NLane(4), .CntWd(2), .Type(SIGNED)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(s_o_ready),
    .i_data(i_data), .i_last(i_last), .i_clear(i_clear), .o_valid(s_o_valid),
    .i_ready(i_ready), .o_data(s_o_data), .o_ovf(s_o_ovf), .o_udf(s_o_udf),
    .o_cnt(s_o_cnt));

  sat_accum_lanes #(.DWd(8), .AWd(8), .NLane(4), .CntWd(3), .Type(UNSIGNED)) dut_u (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(u_o_ready),
    .i_data(i_data), .i_last(i_last), .i_clear(i_clear), .o_valid(u_o_valid),
    .i_ready(i_ready), .o_data(u_o_data), .o_ovf(u_o_ovf), .o_udf(u_o_udf),
    .o_cnt(u_o_cnt));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level, plain integers) --------
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ovf;
    logic [3:0]  udf;
    logic [31:0] cnt;
  } res_t;

  res_t        q_s[$];
  res_t        q_u[$];
  int          acc_s[4], acc_u[4];
  logic [3:0]  fo_s, fu_s, fo_u, fu_u;
  int          cnt_s, cnt_u;

  function automatic void lane_add(input bit sgn, input int acc_in, input logic [7:0] x,
                                   output int acc_out, output bit ov, output bit ud);
    int s;
    s  = acc_in + (sgn ? int'($signed(x)) : int'(x));
    ov = 1'b0;
    ud = 1'b0;
    if (sgn && s > 127) begin
      ov = 1'b1; s = SAT ? 127 : s - 256;
    end else if (sgn && s < -128) begin
      ud = 1'b1; s = SAT ? -128 : s + 256;
    end else if (!sgn && s > 255) begin
      ov = 1'b1; s = SAT ? 255 : s - 256;
    end
    acc_out = s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      acc_s[k] = 0;
      acc_u[k] = 0;
    end
    fo_s = '0; fu_s = '0; fo_u = '0; fu_u = '0;
    cnt_s = 0; cnt_u = 0;
  endfunction

  function automatic void model_beat(input logic [31:0] d);
    int na;
    bit ov, ud;
    for (int k = 0; k < 4; k++) begin
      lane_add(1'b1, acc_s[k], d[k*8 +: 8], na, ov, ud);
      acc_s[k] = na; fo_s[k] = fo_s[k] | ov; fu_s[k] = fu_s[k] | ud;
      lane_add(1'b0, acc_u[k], d[k*8 +: 8], na, ov, ud);
      acc_u[k] = na; fo_u[k] = fo_u[k] | ov; fu_u[k] = fu_u[k] | ud;
    end
    cnt_s = (cnt_s < 3) ? cnt_s + 1 : 3;
    cnt_u = (cnt_u < 7) ? cnt_u + 1 : 7;
  endfunction

  function automatic void model_close();
    res_t rs, ru;
    for (int k = 0; k < 4; k++) begin
      rs.data[k*8 +: 8] = 8'(acc_s[k]);
      ru.data[k*8 +: 8] = 8'(acc_u[k]);
    end
    rs.ovf = fo_s; rs.udf = fu_s; rs.cnt = 32'(cnt_s);
    ru.ovf = fo_u; ru.udf = fu_u; ru.cnt = 32'(cnt_u);
    q_s.push_back(rs);
    q_u.push_back(ru);
    model_clear();
  endfunction

  // One clock: drive at negedge, check outputs, then advance the model to
  // what the coming rising edge should do.
  task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                       input logic c, input logic r);
    bit exp_valid, exp_ready;
    @(negedge clk);
    i_valid = v; i_data = d; i_last = l; i_clear = c; i_ready = r;
    #1;
    exp_valid = (q_s.size() != 0);
    exp_ready = !(exp_valid && !r);
    chk("s_o_valid", 32'(s_o_valid), 32'(exp_valid));
    chk("u_o_valid", 32'(u_o_valid), 32'(exp_valid));
    chk("s_o_ready", 32'(s_o_ready), 32'(exp_ready));
    chk("u_o_ready", 32'(u_o_ready), 32'(exp_ready));
    if (exp_valid) begin
      chk("s_o_data", s_o_data, q_s[0].data);
      chk("s_o_ovf", 32'(s_o_ovf), 32'(q_s[0].ovf));
      chk("s_o_udf", 32'(s_o_udf), 32'(q_s[0].udf));
      chk("s_o_cnt", 32'(s_o_cnt), q_s[0].cnt);
      chk("u_o_data", u_o_data, q_u[0].data);
      chk("u_o_ovf", 32'(u_o_ovf), 32'(q_u[0].ovf));
      chk("u_o_udf", 32'(u_o_udf), 32'(q_u[0].udf));
      chk("u_o_cnt", 32'(u_o_cnt), q_u[0].cnt);
      if (r) begin
        $display("drain s=%h/%h/%h/%0d u=%h/%h/%0d", q_s[0].data, q_s[0].ovf,
                 q_s[0].udf, q_s[0].cnt, q_u[0].data, q_u[0].ovf, q_u[0].cnt);
        void'(q_s.pop_front());
        void'(q_u.pop_front());
      end
    end
    if (c) begin
      model_clear();
    end else if (v && exp_ready) begin
      model_beat(d);
      if (l) model_close();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_valid"}, 32'(s_o_valid), 32'd0);
    chk({tag, "_s_data"}, s_o_data, 32'd0);
    chk({tag, "_s_ovf"}, 32'(s_o_ovf), 32'd0);
    chk({tag, "_s_udf"}, 32'(s_o_udf), 32'd0);
    chk({tag, "_s_cnt"}, 32'(s_o_cnt), 32'd0);
    chk({tag, "_u_valid"}, 32'(u_o_valid), 32'd0);
    chk({tag, "_u_data"}, u_o_data, 32'd0);
    chk({tag, "_u_cnt"}, 32'(u_o_cnt), 32'd0);
  endtask

  // Asynchronous reset pulse taken between edges.
  task automatic do_reset(input string tag);
    i_valid = 1'b0; i_last = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    check_zero(tag);
    q_s.delete();
    q_u.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] b[3];
    int          n;
    logic [31:0] s_data;
    logic [3:0]  s_ovf;
    logic [3:0]  s_udf;
    logic [31:0] u_data;
    logic [3:0]  u_ovf;
    int          cnt;
  } vec_t;

  vec_t vt[3];

  logic [31:0] held;

  initial begin
    model_clear();
    // 100, 50 on lane 0
    vt[0].b[0] = 32'h64; vt[0].b[1] = 32'h32; vt[0].b[2] = 32'h0; vt[0].n = 2;
    vt[0].s_data = SAT ? 32'h7F : 32'h96; vt[0].s_ovf = 4'b0001; vt[0].s_udf = 4'b0;
    vt[0].u_data = 32'h96; vt[0].u_ovf = 4'b0000; vt[0].cnt = 2;
    // 200, 100 on lane 0
    vt[1].b[0] = 32'hC8; vt[1].b[1] = 32'h64; vt[1].b[2] = 32'h0; vt[1].n = 2;
    vt[1].s_data = 32'h2C; vt[1].s_ovf = 4'b0000; vt[1].s_udf = 4'b0;
    vt[1].u_data = SAT ? 32'hFF : 32'h2C; vt[1].u_ovf = 4'b0001; vt[1].cnt = 2;
    // -100, -100, 90 on lane 2
    vt[2].b[0] = 32'h009C0000; vt[2].b[1] = 32'h009C0000; vt[2].b[2] = 32'h005A0000;
    vt[2].n = 3;
    vt[2].s_data = SAT ? 32'h00DA0000 : 32'h00920000;
    vt[2].s_ovf = SAT ? 4'b0000 : 4'b0100; vt[2].s_udf = 4'b0100;
    vt[2].u_data = SAT ? 32'h00FF0000 : 32'h00920000; vt[2].u_ovf = 4'b0100;
    vt[2].cnt = 3;

    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 3; t++) begin
      for (int b = 0; b < vt[t].n; b++) cycle(1'b1, vt[t].b[b], b == vt[t].n - 1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("tbl_s_data", s_o_data, vt[t].s_data);
      chk("tbl_s_ovf", 32'(s_o_ovf), 32'(vt[t].s_ovf));
      chk("tbl_s_udf", 32'(s_o_udf), 32'(vt[t].s_udf));
      chk("tbl_u_data", u_o_data, vt[t].u_data);
      chk("tbl_u_ovf", 32'(u_o_ovf), 32'(vt[t].u_ovf));
      chk("tbl_u_udf", 32'(u_o_udf), 32'd0);
      chk("tbl_cnt", 32'(s_o_cnt), 32'(vt[t].cnt));
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    end

    // Backpressure: result held while a new beat waits, then both handshakes.
    cycle(1'b1, 32'h01020304, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      held = $urandom;
      cycle(1'b1, held, 1'b1, 1'b0, 1'b0);
      chk("bp_ready", 32'(s_o_ready), 32'd0);
      chk("bp_hold", s_o_data, 32'h01020304);
    end
    cycle(1'b1, 32'h05050505, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("bp_next_valid", 32'(s_o_valid), 32'd1);
    chk("bp_next_data", u_o_data, 32'h05050505);

    // Clear concurrent with a last beat discards the frame.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_no_valid", 32'(s_o_valid), 32'd0);
    cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h2, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_next_data", s_o_data, 32'h3);
    chk("clr_next_cnt", 32'(s_o_cnt), 32'd2);

    // Six-beat frame: counter saturates on the 2-bit instance.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h01010101, i == 5, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("cnt_sat_s", 32'(s_o_cnt), 32'd3);
    chk("cnt_u", 32'(u_o_cnt), 32'd6);
    chk("cnt_data", s_o_data, 32'h06060606);

    // Reset mid-frame loses the partial frame.
    cycle(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1);
    do_reset("midrst");
    cycle(1'b1, 32'h5, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_next_data", s_o_data, 32'h5);
    chk("rst_next_cnt", 32'(u_o_cnt), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 4) == 0,
            ($urandom % 40) == 0, ($urandom % 4) != 0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
